// File: rtl/program_counter_unit.sv
// Program counter stage for a multicycle core: holds the fetch address, advances it once per
// retired instruction (sequential, branch or jump), traps misaligned targets, halts, counts retires.
module program_counter_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'('h100),
  parameter int              CNT_W     = 32
) (
  input  logic             Clk,
  input  logic             peripheral_reset,
  input  logic             en_pc,
  input  logic             write_back,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic [XLEN-1:0]  target_addr,
  input  logic             halt_req,
  output logic [XLEN-1:0]  pc_out,
  output logic [XLEN-1:0]  pc_plus4_out,
  output logic             inst_addr_valid,
  output logic             misalign_trap,
  output logic             halt_out,
  output logic [CNT_W-1:0] instret_out
);

  typedef enum logic [1:0] {
    READY,
    FETCHED,
    HALTED
  } state_t;

  state_t           r_state;
  logic [XLEN-1:0]  r_pc;
  logic [CNT_W-1:0] r_instret;
  logic             r_valid;
  logic             r_trap;
  logic             r_halt;

  state_t           w_state_nxt;
  logic [XLEN-1:0]  w_pc_nxt;
  logic [CNT_W-1:0] w_instret_nxt;
  logic             w_trap_nxt;
  logic [XLEN-1:0]  w_seq_pc;
  logic             w_redirect;

  // Sequential address wraps naturally at 2^XLEN, so 0xFFFF_FFFC + 4 -> 0.
  assign w_seq_pc   = r_pc + XLEN'(4);
  assign w_redirect = jump | branch_taken;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_instret_nxt = r_instret;
    w_trap_nxt    = 1'b0;

    case (r_state)
      READY: begin
        if (halt_req)   w_state_nxt = HALTED;
        else if (en_pc) w_state_nxt = FETCHED;
      end
      FETCHED: begin
        if (write_back) begin
          w_instret_nxt = r_instret + CNT_W'(1);
          if (!w_redirect) begin
            w_pc_nxt = w_seq_pc;
          end else if (target_addr[1:0] != 2'b00) begin
            w_pc_nxt   = TRAP_VEC;
            w_trap_nxt = 1'b1;
          end else begin
            w_pc_nxt = target_addr;
          end
          w_state_nxt = halt_req ? HALTED : READY;
        end else if (halt_req) begin
          w_state_nxt = HALTED;
        end
      end
      HALTED:  w_state_nxt = HALTED;
      default: w_state_nxt = READY;
    endcase
  end

  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (peripheral_reset) begin
      r_state   <= READY;
      r_pc      <= RESET_VEC;
      r_instret <= '0;
      r_valid   <= 1'b0;
      r_trap    <= 1'b0;
      r_halt    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_instret <= w_instret_nxt;
      r_valid   <= (w_state_nxt == FETCHED);
      r_trap    <= w_trap_nxt;
      r_halt    <= (w_state_nxt == HALTED);
    end
  end

  assign pc_out          = r_pc;
  assign pc_plus4_out    = w_seq_pc;
  assign inst_addr_valid = r_valid;
  assign misalign_trap   = r_trap;
  assign halt_out        = r_halt;
  assign instret_out     = r_instret;

endmodule

// File: tb/tb_program_counter_unit.sv
// Directed bench for program_counter_unit: fetch/write-back sequences, branch, jump,
// misaligned-target trap, PC wrap, halt behaviour and reset priority.
module tb_program_counter_unit;

  logic        Clk = 1'b0;
  logic        peripheral_reset;
  logic        en_pc;
  logic        write_back;
  logic        branch_taken;
  logic        jump;
  logic [31:0] target_addr;
  logic        halt_req;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4_out;
  logic        inst_addr_valid;
  logic        misalign_trap;
  logic        halt_out;
  logic [31:0] instret_out;

  int n_checks = 0;
  int n_errors = 0;

  program_counter_unit dut (
    .Clk              (Clk),
    .peripheral_reset (peripheral_reset),
    .en_pc            (en_pc),
    .write_back       (write_back),
    .branch_taken     (branch_taken),
    .jump             (jump),
    .target_addr      (target_addr),
    .halt_req         (halt_req),
    .pc_out           (pc_out),
    .pc_plus4_out     (pc_plus4_out),
    .inst_addr_valid  (inst_addr_valid),
    .misalign_trap    (misalign_trap),
    .halt_out         (halt_out),
    .instret_out      (instret_out)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    peripheral_reset = 1'b0;
    en_pc            = 1'b0;
    write_back       = 1'b0;
    branch_taken     = 1'b0;
    jump             = 1'b0;
    target_addr      = '0;
    halt_req         = 1'b0;
  endtask

  task automatic fetch();
    en_pc = 1'b1;
    tick();
    en_pc = 1'b0;
  endtask

  task automatic retire(input logic br, input logic jmp, input logic [31:0] tgt, input logic hlt);
    write_back   = 1'b1;
    branch_taken = br;
    jump         = jmp;
    target_addr  = tgt;
    halt_req     = hlt;
    tick();
    idle_inputs();
  endtask

  task automatic do_reset(input int cycles);
    peripheral_reset = 1'b1;
    repeat (cycles) tick();
    peripheral_reset = 1'b0;
  endtask

  initial begin
    idle_inputs();
    #1;
    do_reset(2);
    check("rst_pc", pc_out, 32'h0);
    check("rst_pc4", pc_plus4_out, 32'h4);
    check("rst_instret", instret_out, 32'h0);
    check("rst_valid", {31'b0, inst_addr_valid}, 32'h0);
    check("rst_trap", {31'b0, misalign_trap}, 32'h0);
    check("rst_halt", {31'b0, halt_out}, 32'h0);

    // Three sequential instructions.
    fetch();
    check("fetch1_valid", {31'b0, inst_addr_valid}, 32'h1);
    check("fetch1_pc", pc_out, 32'h0);
    retire(1'b0, 1'b0, 32'h0, 1'b0);
    check("seq1_pc", pc_out, 32'h4);
    check("seq1_valid", {31'b0, inst_addr_valid}, 32'h0);
    fetch();
    retire(1'b0, 1'b0, 32'h0, 1'b0);
    check("seq2_pc", pc_out, 32'h8);
    fetch();
    retire(1'b0, 1'b0, 32'h0, 1'b0);
    check("seq3_pc", pc_out, 32'hC);
    check("seq3_pc4", pc_plus4_out, 32'h10);
    check("seq3_instret", instret_out, 32'h3);

    // write_back while READY is ignored.
    retire(1'b1, 1'b1, 32'h80, 1'b0);
    check("ready_wb_pc", pc_out, 32'hC);
    check("ready_wb_instret", instret_out, 32'h3);

    // en_pc while FETCHED is ignored.
    fetch();
    fetch();
    check("fetched_en_pc", pc_out, 32'hC);
    check("fetched_en_valid", {31'b0, inst_addr_valid}, 32'h1);
    check("fetched_en_instret", instret_out, 32'h3);

    // Taken branch to aligned target.
    retire(1'b1, 1'b0, 32'h40, 1'b0);
    check("branch_pc", pc_out, 32'h40);
    check("branch_trap", {31'b0, misalign_trap}, 32'h0);
    check("branch_instret", instret_out, 32'h4);

    // Jump to misaligned target traps for exactly one cycle.
    fetch();
    retire(1'b0, 1'b1, 32'h42, 1'b0);
    check("misalign_pc", pc_out, 32'h100);
    check("misalign_trap", {31'b0, misalign_trap}, 32'h1);
    check("misalign_instret", instret_out, 32'h5);
    tick();
    check("misalign_trap_clr", {31'b0, misalign_trap}, 32'h0);
    check("misalign_pc_hold", pc_out, 32'h100);

    // Misaligned target_addr with no redirect: sequential, no trap.
    fetch();
    retire(1'b0, 1'b0, 32'h3, 1'b0);
    check("nored_pc", pc_out, 32'h104);
    check("nored_trap", {31'b0, misalign_trap}, 32'h0);

    // Wrap of the sequential PC.
    fetch();
    retire(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    check("top_pc", pc_out, 32'hFFFF_FFFC);
    check("top_pc4", pc_plus4_out, 32'h0);
    fetch();
    retire(1'b0, 1'b0, 32'h0, 1'b0);
    check("wrap_pc", pc_out, 32'h0);
    check("wrap_instret", instret_out, 32'h8);

    // halt_req together with write_back: pc advances, then the unit halts.
    fetch();
    retire(1'b0, 1'b0, 32'h0, 1'b1);
    check("halt_wb_pc", pc_out, 32'h4);
    check("halt_wb_instret", instret_out, 32'h9);
    check("halt_wb_halt", {31'b0, halt_out}, 32'h1);
    check("halt_wb_valid", {31'b0, inst_addr_valid}, 32'h0);
    fetch();
    retire(1'b0, 1'b1, 32'h200, 1'b0);
    check("halted_pc", pc_out, 32'h4);
    check("halted_instret", instret_out, 32'h9);
    check("halted_halt", {31'b0, halt_out}, 32'h1);
    check("halted_valid", {31'b0, inst_addr_valid}, 32'h0);
    do_reset(1);
    check("unhalt_pc", pc_out, 32'h0);
    check("unhalt_halt", {31'b0, halt_out}, 32'h0);
    check("unhalt_instret", instret_out, 32'h0);

    // halt_req beats en_pc in READY.
    halt_req = 1'b1;
    en_pc    = 1'b1;
    tick();
    idle_inputs();
    check("ready_halt", {31'b0, halt_out}, 32'h1);
    check("ready_halt_valid", {31'b0, inst_addr_valid}, 32'h0);
    do_reset(1);

    // halt_req without write_back in FETCHED halts immediately, pc unchanged.
    fetch();
    halt_req = 1'b1;
    tick();
    idle_inputs();
    check("fetched_halt", {31'b0, halt_out}, 32'h1);
    check("fetched_halt_valid", {31'b0, inst_addr_valid}, 32'h0);
    check("fetched_halt_pc", pc_out, 32'h0);
    check("fetched_halt_instret", instret_out, 32'h0);
    do_reset(1);

    // Reset wins over a write_back in FETCHED.
    fetch();
    fetch();
    retire(1'b0, 1'b0, 32'h0, 1'b0);
    fetch();
    peripheral_reset = 1'b1;
    retire(1'b0, 1'b1, 32'h40, 1'b0);
    check("rstprio_pc", pc_out, 32'h0);
    check("rstprio_instret", instret_out, 32'h0);
    check("rstprio_valid", {31'b0, inst_addr_valid}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
